mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single byte-addressable data RAM port between two requesters: port 0 is the CPU load/store unit and port 1 is the program loader/debug DMA.
- Arbitrates round-robin, latches the winning request and drives the RAM for exactly one access cycle.
- Returns read data and an ack/error to the requester that won.
- Rejects misaligned or illegal size codes without touching the RAM.

Parameters:
- A_WIDTH, 32, address width of requests and of the RAM port.
- D_WIDTH, 32, data width of wd/rdata.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req0 / req1  input  1  request valid, per requester
- addr0 / addr1  input  A_WIDTH  byte address
- bytes0 / bytes1  input  3  funct3 size code: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu
- we0 / we1  input  1  1 = store
- wd0 / wd1  input  D_WIDTH  store data (low bytes used)
- ack0 / ack1  output  1  one-cycle completion pulse
- err0 / err1  output  1  valid with ack; access rejected
- rdata  output  D_WIDTH  load result, valid with ack
- ram_addr  output  A_WIDTH  to RAM address
- ram_bytes  output  3  to RAM size code
- ram_we  output  1  to RAM write enable
- ram_wd  output  D_WIDTH  to RAM write data
- ram_dout  input  D_WIDTH  combinational read data from RAM

Behaviour:
- States: IDLE, ACCESS, RESP.
- Reset: state=IDLE, rr_ptr=0, ack0/1=0, err0/1=0, rdata=0, ram_we=0, ram_addr=0, ram_bytes=0, ram_wd=0, latched fields=0.
- Reset mid-transaction aborts it. No ack is issued, and no write occurs unless the RAM edge already coincided with ACCESS before rst was sampled.
- IDLE, no requests: stay; ram_we=0.
- IDLE, one request: grant it.
- IDLE, both requesting: grant the port rr_ptr points to.
- On grant: latch addr, bytes, we, wd and the granted id; flip rr_ptr to the other port; check legality; go to ACCESS.
- Illegal if any of the following; set err_q:
  - bytes in {011, 110, 111};
  - store with bytes 100 or 101;
  - bytes 001/101 with addr[0]=1;
  - bytes 010 with addr[1:0]!=0.
- ACCESS (exactly 1 cycle): drive ram_addr/ram_bytes/ram_wd from the latches.
  - ram_we = latched_we & ~err_q.
  - The store commits at the end of this cycle.
  - Capture ram_dout into rdata, or 0 if err_q or store.
  - Go to RESP.
- RESP (1 cycle): ack[id]=1; err[id]=err_q; ram_we=0; go to IDLE.
- ack and err are registered outputs: exactly one of ack0/ack1 is high in RESP, never both.
- Latency: request sampled in IDLE at cycle N gives ACCESS at N+1 and ack at N+2. Peak throughput is one access per 3 cycles.
- Requester protocol: hold req and its fields stable until ack. Fields are latched at grant, so later changes are ignored.
- If req is still high in the cycle after ack, it is treated as a new request.
- Starvation-free: with both ports continuously requesting, grants alternate 0,1,0,1…
- ram_bytes and ram_addr outside ACCESS hold their last values. The RAM ignores them while ram_we=0.

Decomposition:
- Package mem_pkg holds:
  - typedef state_t {IDLE, ACCESS, RESP};
  - constants for the funct3 size codes (SZ_B=000, SZ_H=001, SZ_W=010, SZ_BU=100, SZ_HU=101);
  - function is_legal(bytes, we, addr[1:0]).
- One natural sub-module: rr_arb2, a 2-way round-robin grant with pointer update.
- The FSM and datapath latches stay in the top module.

Test Plan:
1. After rst, req1 alone sw addr=0x8 wd=0xDEADBEEF; then req0 lw addr=0x8 → ack1 at N+2 err1=0; ack0 later with rdata=0xDEADBEEF.
2. Store byte 0x80 at addr 0x5 via sb; then lb 0x5 → rdata=0xFFFFFF80; lbu 0x5 → rdata=0x00000080.
3. req0 and req1 both held high for 12 cycles doing lw → grant order 0,1,0,1; acks every 3 cycles, alternating; no double ack.
4. lh addr=0x3 and sw addr=0x6 → err=1 with ack, rdata=0, ram_we never asserted, and subsequent lw 0x4 still returns the old contents.
5. sb with bytes=100 and any request with bytes=111 → err=1, no RAM write.
6. Assert rst during ACCESS of a load → no ack follows, state IDLE; next request is served with ack at N+2, and the rr_ptr=0 grant goes to port 0 when both request.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and size-code helpers for the data RAM port arbiter.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic [2:0] SZ_B  = 3'b000;
   localparam logic [2:0] SZ_H  = 3'b001;
   localparam logic [2:0] SZ_W  = 3'b010;
   localparam logic [2:0] SZ_BU = 3'b100;
   localparam logic [2:0] SZ_HU = 3'b101;

   // Unsigned codes are load-only; halves need even, words need 4-byte alignment.
   function automatic logic is_legal(input logic [2:0] bytes, input logic we,
                                     input logic [1:0] a);
      logic ok;
      case (bytes)
         SZ_B:    ok = 1'b1;
         SZ_H:    ok = ~a[0];
         SZ_W:    ok = (a == 2'b00);
         SZ_BU:   ok = ~we;
         SZ_HU:   ok = ~we & ~a[0];
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin grant; the pointer moves to the loser on every grant.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] i_req,
   input  logic       i_en,
   output logic       o_vld,
   output logic       o_id
);

   logic r_ptr;

   always_comb begin
      o_vld = |i_req;
      o_id  = (i_req == 2'b11) ? r_ptr : i_req[1];
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_ptr <= 1'b0;
      else if (i_en && o_vld)
         r_ptr <= ~o_id;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one data RAM port between the LSU (port 0) and loader/DMA (port 1):
// grant, one RAM access cycle, then a registered ack/err to the winner.
module mem_port_arbiter
   import mem_pkg::*;
#(
   parameter int A_WIDTH = 32,
   parameter int D_WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req0,
   input  logic [A_WIDTH-1:0] addr0,
   input  logic [2:0]         bytes0,
   input  logic               we0,
   input  logic [D_WIDTH-1:0] wd0,
   input  logic               req1,
   input  logic [A_WIDTH-1:0] addr1,
   input  logic [2:0]         bytes1,
   input  logic               we1,
   input  logic [D_WIDTH-1:0] wd1,
   output logic               ack0,
   output logic               ack1,
   output logic               err0,
   output logic               err1,
   output logic [D_WIDTH-1:0] rdata,
   output logic [A_WIDTH-1:0] ram_addr,
   output logic [2:0]         ram_bytes,
   output logic               ram_we,
   output logic [D_WIDTH-1:0] ram_wd,
   input  logic [D_WIDTH-1:0] ram_dout
);

   state_t             r_state;
   logic [A_WIDTH-1:0] r_addr;
   logic [2:0]         r_bytes;
   logic               r_we;
   logic [D_WIDTH-1:0] r_wd;
   logic               r_id;
   logic               r_err;
   logic               r_ack0, r_ack1, r_err0, r_err1;
   logic [D_WIDTH-1:0] r_rdata;
   logic               r_ram_we;

   logic               w_gnt_vld;
   logic               w_gnt_id;
   logic [A_WIDTH-1:0] w_addr;
   logic [2:0]         w_bytes;
   logic               w_we;
   logic [D_WIDTH-1:0] w_wd;
   logic               w_legal;

   rr_arb2 u_arb (
      .clk   (clk),
      .rst   (rst),
      .i_req ({req1, req0}),
      .i_en  (r_state == IDLE),
      .o_vld (w_gnt_vld),
      .o_id  (w_gnt_id)
   );

   always_comb begin
      w_addr  = w_gnt_id ? addr1  : addr0;
      w_bytes = w_gnt_id ? bytes1 : bytes0;
      w_we    = w_gnt_id ? we1    : we0;
      w_wd    = w_gnt_id ? wd1    : wd0;
      w_legal = is_legal(w_bytes, w_we, w_addr[1:0]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_addr   <= '0;
         r_bytes  <= '0;
         r_we     <= 1'b0;
         r_wd     <= '0;
         r_id     <= 1'b0;
         r_err    <= 1'b0;
         r_ack0   <= 1'b0;
         r_ack1   <= 1'b0;
         r_err0   <= 1'b0;
         r_err1   <= 1'b0;
         r_rdata  <= '0;
         r_ram_we <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_ram_we <= 1'b0;
               if (w_gnt_vld) begin
                  r_addr   <= w_addr;
                  r_bytes  <= w_bytes;
                  r_we     <= w_we;
                  r_wd     <= w_wd;
                  r_id     <= w_gnt_id;
                  r_err    <= ~w_legal;
                  // Write enable is registered so it is high for exactly the ACCESS cycle.
                  r_ram_we <= w_we & w_legal;
                  r_state  <= ACCESS;
               end
            end
            ACCESS: begin
               r_ram_we <= 1'b0;
               r_rdata  <= (r_err || r_we) ? '0 : ram_dout;
               r_ack0   <= ~r_id;
               r_ack1   <= r_id;
               r_err0   <= ~r_id & r_err;
               r_err1   <= r_id & r_err;
               r_state  <= RESP;
            end
            RESP: begin
               r_ack0  <= 1'b0;
               r_ack1  <= 1'b0;
               r_err0  <= 1'b0;
               r_err1  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign ack0      = r_ack0;
   assign ack1      = r_ack1;
   assign err0      = r_err0;
   assign err1      = r_err1;
   assign rdata     = r_rdata;
   assign ram_addr  = r_addr;
   assign ram_bytes = r_bytes;
   assign ram_wd    = r_wd;
   assign ram_we    = r_ram_we;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small byte-addressed RAM model.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0, req1, we0, we1;
   logic [31:0] addr0, addr1, wd0, wd1;
   logic [2:0]  bytes0, bytes1;
   logic        ack0, ack1, err0, err1, ram_we;
   logic [31:0] rdata, ram_addr, ram_wd, ram_dout;
   logic [2:0]  ram_bytes;

   int n_cmp = 0;
   int n_err = 0;
   int n_wr  = 0;
   int n_dbl = 0;

   logic [7:0] mem [0:63];
   logic [5:0] ma0, ma1, ma2, ma3;

   always #5 clk = ~clk;

   mem_port_arbiter #(.A_WIDTH(32), .D_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .addr0(addr0), .bytes0(bytes0), .we0(we0), .wd0(wd0),
      .req1(req1), .addr1(addr1), .bytes1(bytes1), .we1(we1), .wd1(wd1),
      .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1), .rdata(rdata),
      .ram_addr(ram_addr), .ram_bytes(ram_bytes), .ram_we(ram_we),
      .ram_wd(ram_wd), .ram_dout(ram_dout)
   );

   always_comb begin
      ma0 = ram_addr[5:0];
      ma1 = ram_addr[5:0] + 6'd1;
      ma2 = ram_addr[5:0] + 6'd2;
      ma3 = ram_addr[5:0] + 6'd3;
      ram_dout = 32'h0;
      case (ram_bytes)
         3'b000:  ram_dout = {{24{mem[ma0][7]}}, mem[ma0]};
         3'b001:  ram_dout = {{16{mem[ma1][7]}}, mem[ma1], mem[ma0]};
         3'b010:  ram_dout = {mem[ma3], mem[ma2], mem[ma1], mem[ma0]};
         3'b100:  ram_dout = {24'h0, mem[ma0]};
         3'b101:  ram_dout = {16'h0, mem[ma1], mem[ma0]};
         default: ram_dout = 32'h0;
      endcase
   end

   always @(posedge clk) begin
      if (ram_we) begin
         n_wr <= n_wr + 1;
         mem[ma0] <= ram_wd[7:0];
         if (ram_bytes[1:0] != 2'b00) mem[ma1] <= ram_wd[15:8];
         if (ram_bytes[1:0] == 2'b10) begin
            mem[ma2] <= ram_wd[23:16];
            mem[ma3] <= ram_wd[31:24];
         end
      end
   end

   always @(negedge clk) if (ack0 && ack1) n_dbl <= n_dbl + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int p, input logic [31:0] a, input logic [2:0] b,
                        input logic w, input logic [31:0] d);
      if (p == 0) begin
         req0 = 1'b1; addr0 = a; bytes0 = b; we0 = w; wd0 = d;
      end else begin
         req1 = 1'b1; addr1 = a; bytes1 = b; we1 = w; wd1 = d;
      end
   endtask

   // Called #1 after an edge with the arbiter idle; leaves it idle again.
   task automatic xfer(input string nm, input int p, input logic [31:0] a,
                       input logic [2:0] b, input logic w, input logic [31:0] d,
                       input logic e_err, input logic [31:0] e_rd);
      drive(p, a, b, w, d);
      @(posedge clk); #1;
      chk({nm, "_acc_we"}, 32'(ram_we), 32'(w & ~e_err));
      chk({nm, "_acc_noack"}, {30'h0, ack1, ack0}, 32'h0);
      chk({nm, "_acc_addr"}, ram_addr, a);
      @(posedge clk); #1;
      chk({nm, "_ack"}, {30'h0, ack1, ack0}, (p == 1) ? 32'h2 : 32'h1);
      chk({nm, "_err"}, {30'h0, err1, err0}, e_err ? ((p == 1) ? 32'h2 : 32'h1) : 32'h0);
      chk({nm, "_rdata"}, rdata, e_rd);
      chk({nm, "_resp_we"}, 32'(ram_we), 32'h0);
      req0 = 1'b0; req1 = 1'b0;
      @(posedge clk); #1;
      chk({nm, "_ack_clr"}, {30'h0, ack1, ack0}, 32'h0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      int w0;
      for (int i = 0; i < 64; i++) mem[i] = 8'h00;
      req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = 0; addr1 = 0; wd0 = 0; wd1 = 0; bytes0 = 0; bytes1 = 0;
      do_reset();

      chk("rst_ack", {30'h0, ack1, ack0}, 32'h0);
      chk("rst_err", {30'h0, err1, err0}, 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_we", 32'(ram_we), 32'h0);
      chk("rst_addr", ram_addr, 32'h0);
      chk("rst_bytes", 32'(ram_bytes), 32'h0);
      chk("rst_wd", ram_wd, 32'h0);

      // 1: DMA word store, then CPU reads it back
      xfer("t1_sw", 1, 32'h8, 3'b010, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0);
      xfer("t1_lw", 0, 32'h8, 3'b010, 1'b0, 32'h0, 1'b0, 32'hDEADBEEF);

      // 2: byte store and signed/unsigned byte loads
      xfer("t2_sb",  0, 32'h5, 3'b000, 1'b1, 32'h12345680, 1'b0, 32'h0);
      xfer("t2_lb",  0, 32'h5, 3'b000, 1'b0, 32'h0, 1'b0, 32'hFFFFFF80);
      xfer("t2_lbu", 1, 32'h5, 3'b100, 1'b0, 32'h0, 1'b0, 32'h00000080);

      // 4: misaligned accesses are rejected and leave RAM untouched
      w0 = n_wr;
      xfer("t4_lh3", 0, 32'h3, 3'b001, 1'b0, 32'h0, 1'b1, 32'h0);
      xfer("t4_sw6", 1, 32'h6, 3'b010, 1'b1, 32'hCAFEF00D, 1'b1, 32'h0);
      xfer("t4_lw4", 0, 32'h4, 3'b010, 1'b0, 32'h0, 1'b0, 32'h00008000);

      // 5: illegal size codes
      xfer("t5_sbu", 0, 32'h10, 3'b100, 1'b1, 32'h000000AA, 1'b1, 32'h0);
      xfer("t5_111", 1, 32'h0, 3'b111, 1'b0, 32'h0, 1'b1, 32'h0);
      chk("t45_no_write", 32'(n_wr - w0), 32'h0);
      xfer("t5_lw10", 1, 32'h10, 3'b010, 1'b0, 32'h0, 1'b0, 32'h0);

      // 3: both ports held; grants alternate starting from port 0 after reset
      do_reset();
      drive(0, 32'h8, 3'b010, 1'b0, 32'h0);
      drive(1, 32'h4, 3'b010, 1'b0, 32'h0);
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         chk($sformatf("t3_ack0_c%0d", k), 32'(ack0), 32'((k == 2) || (k == 8)));
         chk($sformatf("t3_ack1_c%0d", k), 32'(ack1), 32'((k == 5) || (k == 11)));
         if (k == 2 || k == 8)  chk($sformatf("t3_rd0_c%0d", k), rdata, 32'hDEADBEEF);
         if (k == 5 || k == 11) chk($sformatf("t3_rd1_c%0d", k), rdata, 32'h00008000);
      end
      req0 = 1'b0; req1 = 1'b0;
      chk("t3_no_double_ack", 32'(n_dbl), 32'h0);

      // 6: reset during ACCESS aborts; pointer is moved to 1 first so reset must clear it
      xfer("t6_pre", 0, 32'h8, 3'b010, 1'b0, 32'h0, 1'b0, 32'hDEADBEEF);
      drive(0, 32'h8, 3'b010, 1'b0, 32'h0);
      @(posedge clk); #1;
      rst = 1'b1; req0 = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("t6_rst_rdata", rdata, 32'h0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk($sformatf("t6_noack_c%0d", k), {30'h0, ack1, ack0}, 32'h0);
      end
      drive(0, 32'h8, 3'b010, 1'b0, 32'h0);
      drive(1, 32'h4, 3'b010, 1'b0, 32'h0);
      @(posedge clk); #1;
      chk("t6_acc_noack", {30'h0, ack1, ack0}, 32'h0);
      @(posedge clk); #1;
      chk("t6_ack_port0", {30'h0, ack1, ack0}, 32'h1);
      chk("t6_rdata", rdata, 32'hDEADBEEF);
      req0 = 1'b0; req1 = 1'b0;
      repeat (2) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
